// File: rtl/brightness_gain_sched.sv
// Frame-synchronous gain scheduler: debounces the detector's gain request and ramps freq_flag_out one code per step.
// Define BRIGHTNESS_DECAY_EN for a slower downward ramp (DECAY_FRAMES per step) than upward (RAMP_FRAMES).
module brightness_gain_sched #(
  parameter int HOLD_FRAMES  = 4,
  parameter int RAMP_FRAMES  = 2,
  parameter int DECAY_FRAMES = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [2:0] freq_flag_in,
  input  logic       flag_valid,
  input  logic       frame_start,
  input  logic       bypass,
  output logic [2:0] freq_flag_out,
  output logic       gain_busy,
  output logic       gain_update
);

  localparam int MAX_HR = (HOLD_FRAMES > RAMP_FRAMES) ? HOLD_FRAMES : RAMP_FRAMES;
  localparam int MAX_F  = (MAX_HR > DECAY_FRAMES) ? MAX_HR : DECAY_FRAMES;
  localparam int CW     = (MAX_F > 1) ? $clog2(MAX_F) : 1;

  localparam logic [CW-1:0] HOLD_M1 = CW'(HOLD_FRAMES - 1);
  localparam logic [CW-1:0] RAMP_M1 = CW'(RAMP_FRAMES - 1);
`ifdef BRIGHTNESS_DECAY_EN
  localparam logic [CW-1:0] DECAY_M1 = CW'(DECAY_FRAMES - 1);
`endif

  typedef enum logic [1:0] {IDLE, RAMP, BYPASS} state_t;

  state_t        state;
  logic [2:0]    cand;
  logic [2:0]    tgt;
  logic [CW-1:0] stab_cnt;
  logic [CW-1:0] step_cnt;

  logic          accept;
  logic [2:0]    tgt_nxt;
  logic          step_up;
  logic          step_dn;
  logic [2:0]    out_step;
  logic [CW-1:0] step_m1;

  // IDLE looks at the target being written this cycle so RAMP starts together with the new target.
  always_comb begin
    accept  = frame_start && !flag_valid && !bypass && (state != BYPASS)
              && (cand != tgt) && (stab_cnt == HOLD_M1);
    tgt_nxt = accept ? cand : tgt;
  end

  // Direction is taken fresh at every step; up/down already exclude 7/0, so steps cannot wrap.
  always_comb begin
    step_up  = (tgt > freq_flag_out);
    step_dn  = (tgt < freq_flag_out);
    out_step = freq_flag_out;
    if (step_up)
      out_step = freq_flag_out + 3'd1;
    else if (step_dn)
      out_step = freq_flag_out - 3'd1;
`ifdef BRIGHTNESS_DECAY_EN
    step_m1 = step_dn ? DECAY_M1 : RAMP_M1;
`else
    step_m1 = RAMP_M1;
`endif
  end

  assign gain_busy = (state == RAMP);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      cand          <= 3'd0;
      tgt           <= 3'd0;
      stab_cnt      <= '0;
      step_cnt      <= '0;
      freq_flag_out <= 3'd0;
      gain_update   <= 1'b0;
    end else begin
      gain_update <= 1'b0;
      if (frame_start && bypass) begin
        state         <= BYPASS;
        freq_flag_out <= 3'd0;
        gain_update   <= (freq_flag_out != 3'd0);
        cand          <= 3'd0;
        tgt           <= 3'd0;
        stab_cnt      <= '0;
        step_cnt      <= '0;
      end else if (state == BYPASS) begin
        if (frame_start)
          state <= IDLE;
      end else begin
        // A measurement in a frame_start cycle takes precedence over acceptance.
        if (flag_valid) begin
          if (freq_flag_in != cand) begin
            cand     <= freq_flag_in;
            stab_cnt <= '0;
          end
        end else if (frame_start) begin
          if (cand == tgt)
            stab_cnt <= '0;
          else if (stab_cnt == HOLD_M1) begin
            tgt      <= cand;
            stab_cnt <= '0;
          end else
            stab_cnt <= stab_cnt + CW'(1);
        end

        case (state)
          IDLE: begin
            if (tgt_nxt != freq_flag_out) begin
              state    <= RAMP;
              step_cnt <= '0;
            end
          end
          RAMP: begin
            if (frame_start) begin
              if (step_cnt == step_m1) begin
                step_cnt      <= '0;
                freq_flag_out <= out_step;
                gain_update   <= (out_step != freq_flag_out);
                if (out_step == tgt)
                  state <= IDLE;
              end else
                step_cnt <= step_cnt + CW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_brightness_gain_sched.sv
// Self-checking bench for brightness_gain_sched: per-cycle compare against a frame-level model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_brightness_gain_sched;

  localparam int HOLD  = 4;
  localparam int RAMP  = 2;
`ifdef BRIGHTNESS_DECAY_EN
  localparam int DN_STEP = 8;
`else
  localparam int DN_STEP = 2;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [2:0] freq_flag_in = 3'd0;
  logic       flag_valid = 1'b0;
  logic       frame_start = 1'b0;
  logic       bypass = 1'b0;
  logic [2:0] freq_flag_out;
  logic       gain_busy;
  logic       gain_update;

  brightness_gain_sched dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .freq_flag_in  (freq_flag_in),
    .flag_valid    (flag_valid),
    .frame_start   (frame_start),
    .bypass        (bypass),
    .freq_flag_out (freq_flag_out),
    .gain_busy     (gain_busy),
    .gain_update   (gain_update)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int upd_cnt  = 0;
  logic byp_lvl = 1'b0;
  logic run_chk = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: mode 0 = settled, 1 = ramping, 2 = bypassed.
  int m_cand, m_tgt, m_stab, m_step, m_out, m_mode, m_upd;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_cand = 0; m_tgt = 0; m_stab = 0; m_step = 0; m_out = 0; m_mode = 0; m_upd = 0;
    end else begin
      int old_tgt, dir, len;
      m_upd = 0;
      if (frame_start && bypass) begin
        m_upd  = (m_out != 0);
        m_out  = 0; m_mode = 2;
        m_cand = 0; m_tgt = 0; m_stab = 0; m_step = 0;
      end else if (m_mode == 2) begin
        if (frame_start) m_mode = 0;
      end else begin
        old_tgt = m_tgt;
        if (flag_valid) begin
          if (int'(freq_flag_in) != m_cand) begin
            m_cand = int'(freq_flag_in);
            m_stab = 0;
          end
        end else if (frame_start) begin
          if (m_cand == m_tgt) m_stab = 0;
          else if (m_stab == HOLD - 1) begin m_tgt = m_cand; m_stab = 0; end
          else m_stab++;
        end
        if (m_mode == 0) begin
          if (m_tgt != m_out) begin m_mode = 1; m_step = 0; end
        end else if (frame_start) begin
          dir = (old_tgt > m_out) ? 1 : (old_tgt < m_out) ? -1 : 0;
          len = (dir < 0) ? DN_STEP : RAMP;
          if (m_step >= len - 1) begin
            m_step = 0;
            m_out  = m_out + dir;
            m_upd  = (dir != 0);
            if (m_out == old_tgt) m_mode = 0;
          end else m_step++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (run_chk) begin
      chk("model_out",    int'(freq_flag_out), m_out);
      chk("model_busy",   int'(gain_busy),     int'(m_mode == 1));
      chk("model_update", int'(gain_update),   m_upd);
    end
  end

  task automatic cyc(input logic fv, input logic [2:0] v, input logic fs);
    @(negedge clk);
    flag_valid   = fv;
    freq_flag_in = v;
    frame_start  = fs;
    bypass       = byp_lvl;
    @(posedge clk);
    #1;
    if (gain_update) upd_cnt++;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(1'b0, 3'd0, 1'b0);
      cyc(1'b0, 3'd0, 1'b0);
      cyc(1'b0, 3'd0, 1'b0);
      cyc(1'b0, 3'd0, 1'b1);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) cyc(1'b0, 3'd0, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    int u0, k;
    run_chk = 1'b1;
    do_reset();
    chk("reset_out",    int'(freq_flag_out), 0);
    chk("reset_busy",   int'(gain_busy),     0);
    chk("reset_update", int'(gain_update),   0);

    // glitch rejection
    u0 = upd_cnt;
    cyc(1'b1, 3'd5, 1'b0);
    frames(2);
    cyc(1'b1, 3'd0, 1'b0);
    frames(6);
    chk("glitch_out",  int'(freq_flag_out), 0);
    chk("glitch_busy", int'(gain_busy),     0);
    chk("glitch_upd",  upd_cnt - u0,        0);

    // attack 0 -> 3
    u0 = upd_cnt;
    cyc(1'b1, 3'd3, 1'b0);
    frames(3);
    chk("attack_busy_f3", int'(gain_busy), 0);
    frames(1);
    chk("attack_busy_f4", int'(gain_busy), 1);
    chk("attack_out_f4",  int'(freq_flag_out), 0);
    frames(2);
    chk("attack_out_f6",  int'(freq_flag_out), 1);
    frames(3);
    chk("attack_busy_f9", int'(gain_busy), 1);
    frames(1);
    chk("attack_out_f10",  int'(freq_flag_out), 3);
    chk("attack_busy_f10", int'(gain_busy), 0);
    chk("attack_upd",      upd_cnt - u0, 3);

    // saturation at 7, then release to 0
    u0 = upd_cnt;
    cyc(1'b1, 3'd7, 1'b0);
    frames(HOLD + 4 * RAMP + 4);
    chk("sat_out",  int'(freq_flag_out), 7);
    chk("sat_upd",  upd_cnt - u0, 4);
    cyc(1'b1, 3'd0, 1'b0);
    frames(HOLD + 7 * DN_STEP + 2);
    chk("dec_out",  int'(freq_flag_out), 0);
    chk("dec_busy", int'(gain_busy), 0);

    // bypass mid-ramp at out=2
    cyc(1'b1, 3'd3, 1'b0);
    frames(HOLD + 2 * RAMP);
    chk("byp_pre_out", int'(freq_flag_out), 2);
    byp_lvl = 1'b1;
    cyc(1'b0, 3'd0, 1'b0);
    chk("byp_no_effect_yet", int'(freq_flag_out), 2);
    frames(1);
    chk("byp_out",  int'(freq_flag_out), 0);
    chk("byp_busy", int'(gain_busy), 0);
    chk("byp_upd",  int'(gain_update), 1);
    cyc(1'b1, 3'd6, 1'b0);
    frames(HOLD + 1);
    chk("byp_hold_out", int'(freq_flag_out), 0);
    byp_lvl = 1'b0;
    frames(1);
    cyc(1'b1, 3'd3, 1'b0);
    frames(HOLD - 1);
    chk("rearm_busy_early", int'(gain_busy), 0);
    frames(1);
    chk("rearm_busy", int'(gain_busy), 1);
    frames(RAMP);
    chk("rearm_out", int'(freq_flag_out), 1);

    // async reset mid-ramp
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_out",  int'(freq_flag_out), 0);
    chk("async_rst_busy", int'(gain_busy), 0);
    chk("async_rst_upd",  int'(gain_update), 0);
    @(negedge clk);
    reset_n = 1'b1;

    // collision: new measurement in a frame_start cycle blocks acceptance and restarts the hold
    cyc(1'b1, 3'd2, 1'b0);
    frames(HOLD - 1);
    cyc(1'b1, 3'd6, 1'b1);
    chk("coll_busy", int'(gain_busy), 0);
    frames(HOLD - 1);
    chk("coll_busy_hold", int'(gain_busy), 0);
    frames(1);
    chk("coll_busy_acc", int'(gain_busy), 1);

    // one-code decrement 3 -> 2 timing
    do_reset();
    cyc(1'b1, 3'd3, 1'b0);
    frames(HOLD + 3 * RAMP);
    chk("dn_pre_out", int'(freq_flag_out), 3);
    cyc(1'b1, 3'd2, 1'b0);
    frames(HOLD);
    chk("dn_busy", int'(gain_busy), 1);
    k = 0;
    while (freq_flag_out != 3'd2 && k < 20) begin
      frames(1);
      k++;
    end
    chk("dn_frames", k, DN_STEP);

    // randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      if (byp_lvl) begin
        if ($urandom_range(0, 15) == 0) byp_lvl = 1'b0;
      end else if ($urandom_range(0, 199) == 0) byp_lvl = 1'b1;
      cyc($urandom_range(0, 19) == 0, 3'($urandom_range(0, 7)), $urandom_range(0, 2) == 0);
    end
    byp_lvl = 1'b0;
    cyc(1'b0, 3'd0, 1'b0);

    run_chk = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
